// File: rtl/wb_mem_pkg.sv
`default_nettype none
// ============================================================================
// wb_mem_pkg : cycle-type codes, FSM encoding and sizing helpers for wb_mem_bsel
// Revision   : 1.0 - initial release
// ============================================================================
package wb_mem_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_XFER  = 3'd2,
        ST_BURST = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    function automatic int mem_depth(input int data_width, input int size_kb);
        return (size_kb * 1024) / (data_width / 8);
    endfunction

    function automatic int mem_idx_w(input int data_width, input int size_kb);
        int depth;
        depth = mem_depth(data_width, size_kb);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mem_bsel_ram.sv
`default_nettype none
// ============================================================================
// wb_mem_bsel_ram : single-port synchronous RAM, per-byte write enables,
//                   registered read port (drop-in slot for a foundry macro)
// Revision        : 1.0 - initial release
// ============================================================================
module wb_mem_bsel_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16384,
    parameter int IDX_W      = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    re_i,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic [IDX_W-1:0]        addr_i,
    input  logic [DATA_WIDTH-1:0]   wdat_i,
    output logic [DATA_WIDTH-1:0]   rdat_o
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdat_q;

    // Array is never reset so contents survive rst, as an SRAM macro would.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (we_i[k]) begin
                mem_q[addr_i][8*k +: 8] <= wdat_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdat_q <= '0;
        end else if (re_i) begin
            rdat_q <= mem_q[addr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule
`default_nettype wire

// File: rtl/wb_mem_bsel.sv
`default_nettype none
// ============================================================================
// wb_mem_bsel : Wishbone B4 classic SRAM slave with byte lanes, wait states,
//               incrementing bursts and out-of-window error response
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_bsel
    import wb_mem_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          MEM_SIZE_KB = 64,
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [63:0] BASE_ADDR   = 64'd0,
    parameter int          WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    input  logic [2:0]              wb_cti_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int DEPTH = mem_depth(DATA_WIDTH, MEM_SIZE_KB);
    localparam int IDX_W = mem_idx_w(DATA_WIDTH, MEM_SIZE_KB);

    localparam logic [ADDR_WIDTH:0]   SIZE_B   = (ADDR_WIDTH+1)'(64'(MEM_SIZE_KB) * 64'd1024);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [3:0]            WS_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit                    NO_WAIT  = (WAIT_STATES == 0);

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    state_e             state_q;
    logic [3:0]         wcnt_q;
    logic [IDX_W-1:0]   bidx_q;
    logic               ack_q;
    logic               err_q;

    logic [ADDR_WIDTH:0] off;
    logic [IDX_W-1:0]    idx_in;
    logic                in_range;
    logic                req;
    logic                ram_re;
    logic [NB-1:0]       ram_we;
    logic [IDX_W-1:0]    ram_addr;

    // A borrow out of the subtraction lands above SIZE_B, so one compare covers both bounds.
    assign off      = {1'b0, wb_adr_i} - {1'b0, BASE};
    assign in_range = (off < SIZE_B);
    assign idx_in   = off[LSB +: IDX_W];
    assign req      = wb_cyc_i & wb_stb_i;

    always_comb begin
        ram_re   = 1'b0;
        ram_we   = '0;
        ram_addr = idx_in;
        case (state_q)
            ST_IDLE: ram_re = req && in_range && NO_WAIT && !wb_we_i;
            ST_WAIT: ram_re = wb_cyc_i && (wcnt_q == 4'd0) && !wb_we_i;
            ST_XFER: begin
                if (req && wb_we_i) begin
                    ram_we = wb_sel_i;
                end else if (req && (wb_cti_i == CTI_INCR)) begin
                    ram_re   = 1'b1;
                    ram_addr = next_idx(idx_in);
                end
            end
            ST_BURST: begin
                if (req) begin
                    if (wb_we_i) begin
                        ram_we   = wb_sel_i;
                        ram_addr = bidx_q;
                    end else begin
                        ram_re   = 1'b1;
                        ram_addr = next_idx(bidx_q);
                    end
                end
            end
            default: ;
        endcase
        if (rst) begin
            ram_re = 1'b0;
            ram_we = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            bidx_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (!in_range) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else if (NO_WAIT) begin
                            state_q <= ST_XFER;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            wcnt_q  <= WS_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (wcnt_q == 4'd0) begin
                        state_q <= ST_XFER;
                        ack_q   <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                ST_XFER: begin
                    if (req && (wb_cti_i == CTI_INCR)) begin
                        state_q <= ST_BURST;
                        bidx_q  <= next_idx(idx_in);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!wb_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (wb_stb_i) begin
                        bidx_q <= next_idx(bidx_q);
                        if (wb_cti_i == CTI_EOB) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Burst beats are acked combinationally so a stalled strobe is never acked.
    assign wb_ack_o = ack_q | ((state_q == ST_BURST) & req);
    assign wb_err_o = err_q;

    wb_mem_bsel_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .re_i   (ram_re),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdat_i (wb_dat_i),
        .rdat_o (wb_dat_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_bsel.sv
`default_nettype none
// ============================================================================
// tb_wb_mem_bsel : directed vectors and corner sequences for wb_mem_bsel
// Revision       : 1.0 - initial release
// ============================================================================
module tb_wb_mem_bsel;

    localparam logic [2:0] T_CLASSIC = 3'b000;
    localparam logic [2:0] T_INCR    = 3'b010;
    localparam logic [2:0] T_EOB     = 3'b111;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic [2:0]  cyc;
    logic [2:0]  cti;
    wire  [2:0]  ack;
    wire  [2:0]  err;
    wire  [31:0] rdo [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] bexp [4];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [20];

    wb_mem_bsel #(.DATA_WIDTH(32), .MEM_SIZE_KB(64), .ADDR_WIDTH(32), .BASE_ADDR(64'd0), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_stb_i(stb), .wb_cyc_i(cyc[0]), .wb_cti_i(cti),
        .wb_dat_o(rdo[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

    wb_mem_bsel #(.DATA_WIDTH(32), .MEM_SIZE_KB(64), .ADDR_WIDTH(32), .BASE_ADDR(64'd0), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_stb_i(stb), .wb_cyc_i(cyc[1]), .wb_cti_i(cti),
        .wb_dat_o(rdo[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

    wb_mem_bsel #(.DATA_WIDTH(32), .MEM_SIZE_KB(64), .ADDR_WIDTH(32), .BASE_ADDR(64'd0), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
        .wb_stb_i(stb), .wb_cyc_i(cyc[2]), .wb_cti_i(cti),
        .wb_dat_o(rdo[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Classic single access on instance k; returns data/flags seen at the response and its latency.
    task automatic access(input int k, input logic we_v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic got_ack,
                          output logic got_err, output int lat);
        @(posedge clk); #1;
        adr = a; wdat = d; sel = s; we = we_v; cti = T_CLASSIC; stb = 1'b1; cyc[k] = 1'b1;
        got_ack = 1'b0; got_err = 1'b0; lat = 0; rd = '0;
        while (lat < 20 && !got_ack && !got_err) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got_ack = ack[k];
            got_err = err[k];
            rd      = rdo[k];
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc[k] = 1'b0; we = 1'b0;
        @(negedge clk);
        check($sformatf("single-cycle response inst%0d @%0h", k, a), {62'd0, ack[k], err[k]}, 64'd0);
    endtask

    // Read burst on the zero-wait instance; a stall cycle is inserted before beat stall_at.
    task automatic burst_rd(input logic [31:0] a0, input int n, input int stall_at);
        @(posedge clk); #1;
        adr = a0; we = 1'b0; sel = 4'hF; cti = (n > 1) ? T_INCR : T_EOB; stb = 1'b1; cyc[0] = 1'b1;
        for (int b = 0; b < n; b++) begin
            @(posedge clk);
            if (b > 0) begin
                if (b == stall_at) begin
                    #1 stb = 1'b0;
                    @(negedge clk);
                    check($sformatf("burst @%0h stall no ack", a0), {62'd0, ack[0], err[0]}, 64'd0);
                    @(posedge clk);
                end
                #1;
                adr = a0 + 32'(4 * b); stb = 1'b1; cti = (b == n - 1) ? T_EOB : T_INCR;
            end
            @(negedge clk);
            check($sformatf("burst @%0h beat%0d ack", a0, b), {62'd0, ack[0], err[0]}, 64'd2);
            check($sformatf("burst @%0h beat%0d data", a0, b), {32'd0, rdo[0]}, {32'd0, bexp[b]});
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc[0] = 1'b0; cti = T_CLASSIC;
        @(negedge clk);
        check($sformatf("burst @%0h ack after EOB", a0), {63'd0, ack[0]}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] last_rd;
        logic        ga;
        logic        ge;
        logic        seen;
        int          lat;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_AAEF};
        vecs[3]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0016, 32'hAB00_00CD, 4'h9, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0017, 32'h0,         4'hF, 1'b0, 32'hAB34_56CD};
        vecs[7]  = '{1'b0, 32'h0001_0000, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 32'h0001_0010, 32'h5555_5555, 4'hF, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_AAEF};
        vecs[10] = '{1'b1, 32'h0000_0020, 32'h0000_0001, 4'hF, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0024, 32'h0000_0002, 4'hF, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0028, 32'h0000_0003, 4'hF, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_002C, 32'h0000_0004, 4'hF, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_FFFC, 32'h0BAD_CAFE, 4'hF, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'hF, 1'b0, 32'h0BAD_CAFE};
        vecs[16] = '{1'b1, 32'h0000_0000, 32'h00C0_FFEE, 4'hF, 1'b0, 32'h0};
        vecs[17] = '{1'b1, 32'h0000_0050, 32'h1111_1111, 4'hF, 1'b0, 32'h0};
        vecs[18] = '{1'b1, 32'h0000_0054, 32'h2222_2222, 4'hF, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h00C0_FFEE};

        rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = '0; cti = T_CLASSIC;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset ack/err inst%0d", k), {62'd0, ack[k], err[k]}, 64'd0);
            check($sformatf("reset dat inst%0d", k), {32'd0, rdo[k]}, 64'd0);
        end

        last_rd = 32'h0;
        for (int i = 0; i < 20; i++) begin
            access(0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, ga, ge, lat);
            check($sformatf("vec%0d ack/err", i), {62'd0, ga, ge}, vecs[i].exp_err ? 64'd1 : 64'd2);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd1);
            if (!vecs[i].we && !vecs[i].exp_err) begin
                check($sformatf("vec%0d read data", i), {32'd0, rd}, {32'd0, vecs[i].exp_dat});
                last_rd = vecs[i].exp_dat;
            end else begin
                check($sformatf("vec%0d data held", i), {32'd0, rd}, {32'd0, last_rd});
            end
        end

        bexp[0] = 32'd1; bexp[1] = 32'd2; bexp[2] = 32'd3; bexp[3] = 32'd4;
        burst_rd(32'h20, 4, 0);
        burst_rd(32'h20, 4, 2);
        bexp[0] = 32'h0BAD_CAFE; bexp[1] = 32'h00C0_FFEE;
        burst_rd(32'hFFFC, 2, 0);

        access(1, 1'b1, 32'h80, 32'h600D_F00D, 4'hF, rd, ga, ge, lat);
        check("ws2 write ack", {62'd0, ga, ge}, 64'd2);
        check("ws2 write latency", 64'(lat), 64'd3);
        access(1, 1'b0, 32'h80, 32'h0, 4'hF, rd, ga, ge, lat);
        check("ws2 read ack", {62'd0, ga, ge}, 64'd2);
        check("ws2 read latency", 64'(lat), 64'd3);
        check("ws2 read data", {32'd0, rd}, 64'h600D_F00D);
        access(1, 1'b0, 32'h0002_0000, 32'h0, 4'hF, rd, ga, ge, lat);
        check("ws2 range err", {62'd0, ga, ge}, 64'd1);

        access(2, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, rd, ga, ge, lat);
        check("ws3 write latency", 64'(lat), 64'd4);
        @(posedge clk); #1;
        adr = 32'h40; wdat = 32'h1234_5678; sel = 4'hF; we = 1'b1; cti = T_CLASSIC; stb = 1'b1; cyc[2] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        cyc[2] = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ack[2] | err[2];
        end
        check("abort no ack", {63'd0, seen}, 64'd0);
        access(2, 1'b0, 32'h40, 32'h0, 4'hF, rd, ga, ge, lat);
        check("abort read latency", 64'(lat), 64'd4);
        check("abort old value", {32'd0, rd}, 64'hCAFE_F00D);

        @(posedge clk); #1;
        adr = 32'h50; wdat = 32'hAAAA_0001; sel = 4'hF; we = 1'b1; cti = T_INCR; stb = 1'b1; cyc[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst-burst beat1 ack", {63'd0, ack[0]}, 64'd1);
        @(posedge clk); #1;
        adr = 32'h54; wdat = 32'hBBBB_0002;
        @(negedge clk);
        check("rst-burst beat2 ack", {63'd0, ack[0]}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stb = 1'b0; cyc[0] = 1'b0; we = 1'b0; cti = T_CLASSIC;
        @(negedge clk);
        check("rst-burst ack cleared", {62'd0, ack[0], err[0]}, 64'd0);
        check("rst-burst dat cleared", {32'd0, rdo[0]}, 64'd0);
        access(0, 1'b0, 32'h50, 32'h0, 4'hF, rd, ga, ge, lat);
        check("rst-burst idle latency", 64'(lat), 64'd1);
        check("rst-burst beat1 kept", {32'd0, rd}, 64'hAAAA_0001);
        access(0, 1'b0, 32'h54, 32'h0, 4'hF, rd, ga, ge, lat);
        check("rst-burst beat2 dropped", {32'd0, rd}, 64'h2222_2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_mem_bsel.md
Name: wb_mem_bsel

Overview:
Wishbone B4 classic slave memory, the successor to the current single-byte-write RAM.
- Adds full byte-lane writes via wb_sel_i, registered reads, programmable wait states and address-range error response.
- Supports linear incrementing bursts via wb_cti_i.
- Sits on the core's data/instruction bus as a generic on-chip SRAM target, directly replaceable by an SRAM macro.

Parameters:
- DATA_WIDTH, 32, bus and word width; multiple of 8; 32 or 64.
- MEM_SIZE_KB, 64, capacity in KB; depth = MEM_SIZE_KB*1024/(DATA_WIDTH/8).
- ADDR_WIDTH, 32, width of the byte address on wb_adr_i.
- BASE_ADDR, 0, byte base address of the memory window; aligned to its size.
- WAIT_STATES, 0, extra cycles inserted before the first ack of each access; 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_adr_i  in  ADDR_WIDTH  byte address
- wb_dat_i  in  DATA_WIDTH  write data
- wb_sel_i  in  DATA_WIDTH/8  byte-lane enables; bit k maps to bits 8k+7:8k
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
- wb_dat_o  out  DATA_WIDTH  read data, registered
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination for out-of-window addresses

Behaviour:
- Reset:
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0, FSM=IDLE, wait counter=0.
  - Memory contents are NOT cleared; they are undefined after power-up and retained across rst.
- Decode:
  - word index = (wb_adr_i-BASE_ADDR)>>log2(DATA_WIDTH/8).
  - Address low bits are ignored; lane selection comes only from wb_sel_i.
  - In-range means BASE_ADDR <= adr < BASE_ADDR + size.
- FSM states: IDLE, WAIT, XFER, BURST, ERR.
- IDLE:
  - Entered on the edge where cyc&stb is sampled.
  - Out of range -> ERR.
  - Else, if WAIT_STATES>0 -> WAIT with counter=WAIT_STATES-1.
  - Else -> XFER.
- WAIT: counter decrements each cycle; at 0 -> XFER.
- XFER:
  - wb_ack_o=1 for one cycle.
  - Read data is valid in the same cycle as ack.
  - Write commits on the edge ending the ack cycle, only for lanes with wb_sel_i=1.
  - wb_sel_i=0 is a legal no-op and is still acked.
- Single-access latency: ack asserted WAIT_STATES+1 cycles after the request edge.
- After an ack, the FSM returns to IDLE and ignores stb on that edge; classic throughput is one access per WAIT_STATES+2 cycles.
- Burst entry: on the ack edge in XFER, if wb_cti_i=010 and stb=1 -> BURST.
- BURST:
  - No wait states.
  - ack is asserted in every cycle with cyc&stb=1 and deasserted in cycles with stb=0; the internal address is held during those stall cycles.
  - Read data is prefetched from an internal address counter of last acked word+1, wrapping modulo depth.
  - Writes use the internal counter address together with wb_dat_i and wb_sel_i.
  - Exit to IDLE on an acked beat with cti=111, or whenever cyc=0.
  - A beat whose address leaves the window after wrap does not error: wrap is inside the memory.
- ERR:
  - wb_err_o=1 for one cycle, no memory access, then IDLE.
  - ack and err are never high together.
- cyc drop: cyc=0 in WAIT or BURST aborts to IDLE with no write and no ack.
- rst mid-operation: FSM->IDLE and outputs cleared on that edge; any pending write is discarded.
- wb_dat_o holds its last read value when not acked; after a write ack it holds its previous value.

Decomposition:
- Package wb_mem_pkg holds:
  - CTI constants (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111)
  - FSM state encoding
  - a function computing depth and index width from DATA_WIDTH/MEM_SIZE_KB
- One sub-module, wb_mem_bsel_ram: single-port synchronous RAM with per-byte write enables and registered read. This keeps it swappable for a foundry macro.

Test Plan:
- Lane write merge (WAIT_STATES=0): write 0xDEADBEEF sel=1111 @0x10, then 0x0000AA00 sel=0010 @0x10 -> read @0x10 returns 0xDEADAAEF; each ack lasts exactly 1 cycle, 1 cycle after request.
- Wait states (WAIT_STATES=2): read request -> ack on the 3rd cycle after the request edge; wb_dat_o is stable with ack.
- Out of range (64KB, BASE 0): read @0x0001_0000 -> wb_err_o=1 for 1 cycle, ack never asserts; memory is unchanged.
- Burst read: preload 0x20..0x2C with 1,2,3,4; 4 beats cti=010,010,010,111 @0x20 -> acks on 4 consecutive cycles returning 1,2,3,4, then ack=0; insert one stb=0 stall -> one idle gap, data order preserved.
- Abort: WAIT_STATES=3 write 0x12345678 @0x40, drop cyc in WAIT -> no ack; read @0x40 returns the old value.
- Reset mid-burst: assert rst during beat 2 of a write burst -> ack=0 next cycle, FSM IDLE; beat 1 data is retained, beat 2 is not written.
